// File: rtl/play_adjacent_edge_if.sv
// Board-state bus for O strategy blocks: X/O occupancy in, one-hot move recommendation out.
interface play_adjacent_edge_if;
    localparam int unsigned N_SQ = 9;

    logic [N_SQ-1:0] xin;
    logic [N_SQ-1:0] oin;
    logic [N_SQ-1:0] oout;
    logic            hit;

    modport master (output xin, output oin, input oout, input hit);
    modport slave  (input xin, input oin, output oout, output hit);
endinterface

// File: rtl/play_adjacent_edge.sv
// O-player defence against the opposite-corner fork: when X holds two opposite corners
// and O holds the centre, recommend the first empty edge (5, 3, 7, 1). Registered output.
module play_adjacent_edge (
    input  logic                clk,
    input  logic                rst_n,
    play_adjacent_edge_if.slave bus
);
    localparam int unsigned N_SQ = 9;

    logic [N_SQ-1:0] w_empty;
    logic            w_corner_pair;
    logic            w_legal;
    logic            w_trigger;
    logic [N_SQ-1:0] w_next_oout;
    logic [N_SQ-1:0] r_oout;
    logic            r_hit;

    assign w_empty       = ~(bus.xin | bus.oin);
    assign w_corner_pair = (bus.xin[8] & bus.xin[0]) | (bus.xin[6] & bus.xin[2]);
    assign w_legal       = ((bus.xin & bus.oin) == '0);
    assign w_trigger     = w_legal & bus.oin[4] & w_corner_pair;

    // Fixed edge priority; a one-hot result can only land on an empty edge.
    always_comb begin
        w_next_oout = '0;
        if (w_trigger) begin
            if (w_empty[5])      w_next_oout[5] = 1'b1;
            else if (w_empty[3]) w_next_oout[3] = 1'b1;
            else if (w_empty[7]) w_next_oout[7] = 1'b1;
            else if (w_empty[1]) w_next_oout[1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_oout <= '0;
            r_hit  <= 1'b0;
        end else begin
            r_oout <= w_next_oout;
            r_hit  <= |w_next_oout;
        end
    end

    assign bus.oout = r_oout;
    assign bus.hit  = r_hit;
endmodule

// File: tb/tb_play_adjacent_edge.sv
// Directed-vector bench for play_adjacent_edge with hand-computed expectations.
module tb_play_adjacent_edge;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    play_adjacent_edge_if bus ();

    play_adjacent_edge dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.xin  = 9'b100000001;
        bus.oin  = 9'b000010000;
        tick();
        checks++;
        if (bus.oout !== 9'b000000000) begin
            failures++;
            $display("FAIL reset_oout got=%b exp=%b", bus.oout, 9'b000000000);
        end
        checks++;
        if (bus.hit !== 1'b0) begin
            failures++;
            $display("FAIL reset_hit got=%b exp=%b", bus.hit, 1'b0);
        end
        rst_n   = 1'b1;
        bus.xin = 9'b000000000;
        bus.oin = 9'b000000000;
        tick();
        checks++;
        if (bus.oout !== 9'b000000000 || bus.hit !== 1'b0) begin
            failures++;
            $display("FAIL empty_board got oout=%b hit=%b exp oout=%b hit=0", bus.oout, bus.hit, 9'b0);
        end
    endtask

    task automatic test_early_game();
        bus.xin = 9'b000000001;
        bus.oin = 9'b000000000;
        tick();
        checks++;
        if (bus.oout !== 9'b000000000 || bus.hit !== 1'b0) begin
            failures++;
            $display("FAIL early_x_only got oout=%b hit=%b exp oout=%b hit=0", bus.oout, bus.hit, 9'b0);
        end
        bus.oin = 9'b000010000;
        tick();
        checks++;
        if (bus.oout !== 9'b000000000 || bus.hit !== 1'b0) begin
            failures++;
            $display("FAIL early_one_corner got oout=%b hit=%b exp oout=%b hit=0", bus.oout, bus.hit, 9'b0);
        end
    endtask

    // Triggering positions, exercising every step of the edge priority.
    task automatic test_priority();
        logic [8:0] xv [6];
        logic [8:0] ov [6];
        logic [8:0] ev [6];
        xv[0] = 9'b100000001; ov[0] = 9'b000010000; ev[0] = 9'b000100000;
        xv[1] = 9'b100000001; ov[1] = 9'b000110000; ev[1] = 9'b000001000;
        xv[2] = 9'b001000100; ov[2] = 9'b000010000; ev[2] = 9'b000100000;
        xv[3] = 9'b100001001; ov[3] = 9'b000110000; ev[3] = 9'b010000000;
        xv[4] = 9'b110000001; ov[4] = 9'b000111000; ev[4] = 9'b000000010;
        xv[5] = 9'b101000101; ov[5] = 9'b000010000; ev[5] = 9'b000100000;
        for (int i = 0; i < 6; i++) begin
            bus.xin = xv[i];
            bus.oin = ov[i];
            tick();
            checks++;
            if (bus.oout !== ev[i]) begin
                failures++;
                $display("FAIL priority_oout[%0d] got=%b exp=%b", i, bus.oout, ev[i]);
            end
            checks++;
            if (bus.hit !== 1'b1) begin
                failures++;
                $display("FAIL priority_hit[%0d] got=%b exp=1", i, bus.hit);
            end
        end
    endtask

    // Positions that must never produce a recommendation.
    task automatic test_no_trigger();
        logic [8:0] xv [5];
        logic [8:0] ov [5];
        xv[0] = 9'b010000100; ov[0] = 9'b000010000; // corner plus edge
        xv[1] = 9'b100010001; ov[1] = 9'b000000000; // X owns centre
        xv[2] = 9'b100000001; ov[2] = 9'b000000000; // O lacks centre
        xv[3] = 9'b110000011; ov[3] = 9'b000111000; // every edge filled
        xv[4] = 9'b101000000; ov[4] = 9'b000010000; // adjacent corners
        for (int i = 0; i < 5; i++) begin
            bus.xin = xv[i];
            bus.oin = ov[i];
            tick();
            checks++;
            if (bus.oout !== 9'b000000000 || bus.hit !== 1'b0) begin
                failures++;
                $display("FAIL no_trigger[%0d] got oout=%b hit=%b exp oout=%b hit=0", i, bus.oout, bus.hit, 9'b0);
            end
        end
    endtask

    task automatic test_illegal_and_mid_reset();
        bus.xin = 9'b100010001;
        bus.oin = 9'b000010000;
        tick();
        checks++;
        if (bus.oout !== 9'b000000000 || bus.hit !== 1'b0) begin
            failures++;
            $display("FAIL illegal_overlap got oout=%b hit=%b exp oout=%b hit=0", bus.oout, bus.hit, 9'b0);
        end
        bus.xin = 9'b100000001;
        tick();
        checks++;
        if (bus.oout !== 9'b000100000) begin
            failures++;
            $display("FAIL pre_reset_oout got=%b exp=%b", bus.oout, 9'b000100000);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus.oout !== 9'b000000000 || bus.hit !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got oout=%b hit=%b exp oout=%b hit=0", bus.oout, bus.hit, 9'b0);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.oout !== 9'b000100000 || bus.hit !== 1'b1) begin
            failures++;
            $display("FAIL post_reset got oout=%b hit=%b exp oout=%b hit=1", bus.oout, bus.hit, 9'b000100000);
        end
    endtask

    // Output holds until the next edge, then follows the new input every cycle.
    task automatic test_back_to_back();
        bus.xin = 9'b100000001;
        bus.oin = 9'b000010000;
        tick();
        bus.oin = 9'b000110000;
        #2;
        checks++;
        if (bus.oout !== 9'b000100000) begin
            failures++;
            $display("FAIL latency_hold got=%b exp=%b", bus.oout, 9'b000100000);
        end
        tick();
        checks++;
        if (bus.oout !== 9'b000001000) begin
            failures++;
            $display("FAIL b2b_step1 got=%b exp=%b", bus.oout, 9'b000001000);
        end
        bus.xin = 9'b010000100;
        bus.oin = 9'b000010000;
        tick();
        checks++;
        if (bus.oout !== 9'b000000000 || bus.hit !== 1'b0) begin
            failures++;
            $display("FAIL b2b_step2 got oout=%b hit=%b exp oout=%b hit=0", bus.oout, bus.hit, 9'b0);
        end
        bus.xin = 9'b001000100;
        tick();
        checks++;
        if (bus.oout !== 9'b000100000 || bus.hit !== 1'b1) begin
            failures++;
            $display("FAIL b2b_step3 got oout=%b hit=%b exp oout=%b hit=1", bus.oout, bus.hit, 9'b000100000);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.xin  = '0;
        bus.oin  = '0;
        @(negedge clk);
        test_reset();
        test_early_game();
        test_priority();
        test_no_trigger();
        test_illegal_and_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
